// File: rtl/lfsr.sv
// Fibonacci LFSR used as a pseudo-random pattern source.
// The state shifts toward the MSB each enabled clock, and the XOR of the
// tap bits enters the LSB. A seed is loaded on reset, or on the first
// enabled clock after power-up, so no reset is needed before first use.
// The all-zeros state is a deliberate fixed point and has no escape logic.
module lfsr #(
  parameter int OUTPUT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enb,
  input  logic [OUTPUT_WIDTH-1:0] seed,
  output logic [OUTPUT_WIDTH-1:0] out
);

  // Maximal-length tap mask for a given width.
  // Bit k-1 is set for tap k.
  function automatic logic [15:0] tap_mask(input int n);
    logic [15:0] m;
    case (n)
      2:       m = 16'h0003;
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // Reject unsupported widths at elaboration.
  generate
    if (OUTPUT_WIDTH < 2 || OUTPUT_WIDTH > 16) begin : g_bad_width
      $error("lfsr: OUTPUT_WIDTH must be in the range 2..16");
    end
  endgenerate

  localparam logic [15:0] TAP_MASK = tap_mask(OUTPUT_WIDTH);

  // Power-up values come from the register initialisers. The pending flag
  // makes the first enabled clock load the seed.
  logic [OUTPUT_WIDTH-1:0] out_r          = '0;
  logic                    load_pending_r = 1'b1;
  logic                    fb_s;

  // Feedback bit: parity of the tapped state bits.
  always_comb begin
    fb_s = ^(out_r & TAP_MASK[OUTPUT_WIDTH-1:0]);
  end

  // State update. Enable gates everything, including reset.
  // After that, reset or a pending load takes priority over a shift.
  always_ff @(posedge clk) begin
    if (!enb) begin
      out_r          <= out_r;
      load_pending_r <= load_pending_r;
    end else if (rst || load_pending_r) begin
      out_r          <= seed;
      load_pending_r <= 1'b0;
    end else begin
      out_r          <= {out_r[OUTPUT_WIDTH-2:0], fb_s};
      load_pending_r <= 1'b0;
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr.
// A table of N=4 vectors is checked through a scoreboard queue. Parallel
// power-up sequences cover the zero-seed fixed point and the full periods
// for N=8 and N=16.
module tb_lfsr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // N=4 main instance: table-driven.
  logic       enb4 = 1'b0, rst4 = 1'b0;
  logic [3:0] seed4 = 4'h0;
  logic [3:0] out4;
  lfsr #(.OUTPUT_WIDTH(4)) u4 (.clk(clk), .rst(rst4), .enb(enb4), .seed(seed4), .out(out4));

  // N=4 zero-seed instance, enabled from power-up.
  logic       enbz = 1'b1, rstz = 1'b0;
  logic [3:0] seedz = 4'h0;
  logic [3:0] outz;
  lfsr #(.OUTPUT_WIDTH(4)) uz (.clk(clk), .rst(rstz), .enb(enbz), .seed(seedz), .out(outz));

  // N=8 period instance.
  logic       enb8 = 1'b1, rst8 = 1'b0;
  logic [7:0] seed8 = 8'h01;
  logic [7:0] out8;
  lfsr #(.OUTPUT_WIDTH(8)) u8 (.clk(clk), .rst(rst8), .enb(enb8), .seed(seed8), .out(out8));

  // N=16 period instance.
  logic        enb16 = 1'b1, rst16 = 1'b0;
  logic [15:0] seed16 = 16'hACE1;
  logic [15:0] out16;
  lfsr #(.OUTPUT_WIDTH(16)) u16 (.clk(clk), .rst(rst16), .enb(enb16), .seed(seed16), .out(out16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       enb;
    logic       rst;
    logic [3:0] seed;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb_q[$];
  bit         period_done = 1'b0;

  task automatic add(input logic e, input logic r, input logic [3:0] s,
                     input logic [3:0] x, input string n);
    vec_t v;
    v.enb = e; v.rst = r; v.seed = s; v.exp = x; v.name = n;
    vecs.push_back(v);
  endtask

  // Main sequence: the N=4 vector table, checked through the scoreboard.
  initial begin
    logic [3:0] ref_seq[15];
    logic [3:0] got;
    ref_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // Power-up hold, with reset masked by enb=0.
    add(1'b0, 1'b0, 4'h0, 4'h0, "pwr_hold");
    add(1'b0, 1'b1, 4'h0, 4'h0, "rst_masked");
    // First enabled clock loads the seed, then the full reference loop.
    add(1'b1, 1'b0, 4'h1, 4'h1, "first_load");
    for (int i = 1; i < 15; i++) add(1'b1, 1'b0, 4'h1, ref_seq[i], "ref_seq");
    add(1'b1, 1'b0, 4'h1, 4'h1, "wrap");
    // A seed change with no load in progress has no effect.
    // Advance to 1011.
    for (int i = 1; i <= 9; i++) add(1'b1, 1'b0, 4'hF, ref_seq[i], "seed_ignored");
    // Mid-sequence reset reloads the seed, then advances from it.
    add(1'b1, 1'b1, 4'h1, 4'h1, "mid_reset");
    add(1'b1, 1'b0, 4'h1, 4'h2, "post_reset");
    add(1'b1, 1'b0, 4'h1, 4'h4, "advance");
    // Disable for 5 clocks with rst toggling: state holds at 0100.
    for (int i = 0; i < 5; i++) add(1'b0, i[0], 4'h9, 4'h4, "hold_dis");
    add(1'b1, 1'b0, 4'h9, 4'h9, "reenable");
    // Reset with a different seed.
    add(1'b1, 1'b1, 4'hA, 4'hA, "reseed");
    add(1'b1, 1'b0, 4'h3, 4'h5, "reseed_adv");

    // Check the initial value before any edge.
    #1;
    check("power_up_out", 32'(out4), 32'h0);

    foreach (vecs[i]) begin
      enb4  = vecs[i].enb;
      rst4  = vecs[i].rst;
      seed4 = vecs[i].seed;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        got = sb_q.pop_front();
        check(vecs[i].name, 32'(out4), 32'(got));
      end
    end
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    // Wait, with a bound, for the parallel period checks to finish.
    for (int c = 0; c < 70000 && !period_done; c++) @(posedge clk);
    if (!period_done) check("period_timeout", 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Parallel power-up sequences: the zero-seed fixed point and the period
  // and no-repeat checks for N=8 and N=16.
  initial begin
    bit seen8[256];
    bit seen16[65536];
    int ret8 = 0, ret16 = 0, rep8 = 0, rep16 = 0, cnt8 = 0, cnt16 = 0;
    for (int c = 1; c <= 65540; c++) begin
      @(posedge clk); #1;
      if (c <= 17) check("zero_fixed", 32'(outz), 32'h0);
      if (c == 1) begin
        check("load8", 32'(out8), 32'h01);
        check("load16", 32'(out16), 32'hACE1);
      end
      if (ret8 == 0) begin
        if (c > 1 && out8 == 8'h01) ret8 = c - 1;
        else begin
          if (seen8[out8]) rep8++;
          else cnt8++;
          seen8[out8] = 1'b1;
        end
      end
      if (ret16 == 0) begin
        if (c > 1 && out16 == 16'hACE1) ret16 = c - 1;
        else begin
          if (seen16[out16]) rep16++;
          else cnt16++;
          seen16[out16] = 1'b1;
        end
      end
      if (ret8 != 0 && ret16 != 0 && c > 17) break;
    end
    check("period8", 32'(ret8), 32'd255);
    check("norepeat8", 32'(rep8), 32'd0);
    check("distinct8", 32'(cnt8), 32'd255);
    check("nozero8", 32'(seen8[0]), 32'd0);
    check("period16", 32'(ret16), 32'd65535);
    check("norepeat16", 32'(rep16), 32'd0);
    check("distinct16", 32'(cnt16), 32'd65535);
    check("nozero16", 32'(seen16[0]), 32'd0);
    period_done = 1'b1;
  end

endmodule
